mem_bus_arbiter: RTL and testbench

//  Two-master arbiter for the single-slave memory bus (Read/Write/Address/Write_data/Read_data).

---
 rtl/mem_bus_arbiter.sv | 85 ++++++++
 tb/tb_mem_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master single-slave memory bus arbiter with registered grant and bounded lock.
// Define ARB_ROUND_ROBIN_EN to break ties toward the master not served last; default is fixed priority to master 0.
module mem_bus_arbiter #(
    parameter int MAX_LOCK = 8,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          bus_read,
    output logic          bus_write,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic [1:0]    gnt
);
    localparam int CW = $clog2(MAX_LOCK) + 1;
    localparam logic [CW-1:0] LOCK_TOP = CW'(MAX_LOCK - 1);
    typedef enum logic [1:0] {NONE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
    state_t        r_state;
    logic [CW-1:0] r_lock_cnt;
    logic          w_g0, w_g1, w_locked, w_force, w_elig0, w_elig1, w_tie1;

    assign gnt       = r_state;
    assign w_g0      = r_state == G0;
    assign w_g1      = r_state == G1;
    assign m0_ack    = w_g0 & m0_req;
    assign m1_ack    = w_g1 & m1_req;
    assign m0_rdata  = w_g0 ? bus_rdata : '0;
    assign m1_rdata  = w_g1 ? bus_rdata : '0;
    assign bus_read  = m0_ack ? m0_read : m1_ack & m1_read;
    assign bus_write = m0_ack ? m0_write : m1_ack & m1_write;
    assign bus_addr  = m0_ack ? m0_addr : m1_ack ? m1_addr : '0;
    assign bus_wdata = m0_ack ? m0_wdata : m1_ack ? m1_wdata : '0;
    // A locked ack keeps the grant unless the lock has run its course while the other master waits.
    assign w_locked  = (m0_ack & m0_lock) | (m1_ack & m1_lock);
    assign w_force   = (r_lock_cnt == LOCK_TOP) & (w_g0 ? m1_req : m0_req);
    // A master just acked without lock still holds a stale request, so it sits out one edge.
    assign w_elig0   = m0_req & ~m0_ack;
    assign w_elig1   = m1_req & ~m1_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;
    always_ff @(posedge clk) begin
        if (!reset)
            r_last <= 1'b1;
        else if (m0_ack | m1_ack)
            r_last <= m1_ack;
    end
    assign w_tie1 = ~r_last;
`else
    assign w_tie1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= NONE;
            r_lock_cnt <= '0;
        end else if (w_locked && !w_force) begin
            r_lock_cnt <= r_lock_cnt + CW'(r_lock_cnt != LOCK_TOP);
        end else if (w_locked) begin
            r_state    <= w_g0 ? G1 : G0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= (w_elig0 && !(w_elig1 && w_tie1)) ? G0 : w_elig1 ? G1 : NONE;
            r_lock_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table, corner sequences and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int ML = 8, AW = 32, DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0;
    logic m0_req, m0_lock, m0_read, m0_write, m1_req, m1_lock, m1_read, m1_write;
    logic [AW-1:0] m0_addr, m1_addr, bus_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_wdata, bus_rdata;
    logic m0_ack, m1_ack, bus_read, bus_write;
    logic [1:0] gnt;
    logic [DW-1:0] mem [64];
    int n_pass = 0, n_tot = 0;
    int owner, run, last;

    typedef struct { logic r0, l0, r1, l1; logic [1:0] g; logic a0, a1; } vec_t;
    vec_t tbl [12];

    mem_bus_arbiter #(.MAX_LOCK(ML), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_read(m0_read), .m0_write(m0_write),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_read(m1_read), .m1_write(m1_write),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .gnt(gnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (bus_write) mem[bus_addr[5:0]] <= bus_wdata;
    assign bus_rdata = mem[bus_addr[5:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {m0_req, m0_lock, m0_read, m0_write, m1_req, m1_lock, m1_read, m1_write} = '0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        reset = 1'b1;
    endtask

    task automatic model_check();
        logic a0, a1;
        logic [1:0] eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, r0, r1;
        a0 = owner == 0 && m0_req;
        a1 = owner == 1 && m1_req;
        eg = owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00;
        ea = a0 ? m0_addr : a1 ? m1_addr : '0;
        ew = a0 ? m0_wdata : a1 ? m1_wdata : '0;
        r0 = owner == 0 ? mem[ea[5:0]] : '0;
        r1 = owner == 1 ? mem[ea[5:0]] : '0;
        chk("rnd_gnt_ack", {gnt, m0_ack, m1_ack}, {eg, a0, a1});
        chk("rnd_rw", {bus_read, bus_write}, {a0 ? m0_read : a1 & m1_read, a0 ? m0_write : a1 & m1_write});
        chk("rnd_addr", bus_addr, ea);
        chk("rnd_wdata", bus_wdata, ew);
        chk("rnd_rdata", {m0_rdata, m1_rdata}, {r0, r1});
    endtask

    task automatic model_step();
        logic req [2];
        logic lk [2];
        logic e0, e1;
        int cur;
        cur = owner;
        req[0] = m0_req; req[1] = m1_req; lk[0] = m0_lock; lk[1] = m1_lock;
        if (!reset) begin
            owner = -1; run = 0; last = 1;
            return;
        end
        if (cur >= 0 && req[cur] && lk[cur]) begin
            if (run >= ML - 1 && req[1 - cur]) begin
                owner = 1 - cur;
                run = 0;
            end else if (run < ML - 1) run++;
        end else begin
            e0 = req[0] && cur != 0;
            e1 = req[1] && cur != 1;
            run = 0;
            if (e0 && e1) owner = RR ? 1 - last : 0;
            else owner = e0 ? 0 : e1 ? 1 : -1;
        end
        if (cur >= 0 && req[cur]) last = cur;
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{1, 0, 1, 0, 2'b00, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 2'b01, 1, 0};
        tbl[2]  = '{1, 0, 1, 0, 2'b10, 0, 1};
        tbl[3]  = '{1, 0, 1, 0, 2'b01, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 2'b10, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 2'b01, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 2'b00, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 2'b10, 0, 1};
        tbl[8]  = '{0, 0, 1, 0, 2'b00, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 2'b10, 0, 1};
        tbl[10] = '{0, 0, 1, 1, 2'b10, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 2'b10, 0, 0};
        idle();
        // Reset held with both masters requesting, then released.
        {m0_req, m1_req, m0_read, m1_write} = '1;
        m0_addr = 32'h44; m1_addr = 32'h48; m1_wdata = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rst_gnt_ack", {gnt, m0_ack, m1_ack}, 4'b0000);
            chk("rst_bus", {bus_read, bus_write, bus_addr, bus_wdata}, '0);
            chk("rst_rdata", {m0_rdata, m1_rdata}, '0);
        end
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_release_gnt", {gnt, m0_ack}, 3'b011);
        // Write then read back through master 0.
        do_reset();
        m0_req = 1; m0_write = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_latency", {gnt, m0_ack}, 3'b000);
        tick();
        @(negedge clk);
        chk("wr_ack", {m0_ack, bus_write, bus_read}, 3'b110);
        chk("wr_bus", {bus_addr, bus_wdata}, {32'h10, 32'hDEADBEEF});
        tick();
        m0_write = 0; m0_read = 1; m0_wdata = '0;
        @(negedge clk);
        chk("rd_latency", {gnt, m0_ack}, 3'b000);
        tick();
        @(negedge clk);
        chk("rd_ack", {m0_ack, bus_read, bus_addr}, {2'b11, 32'h10});
        chk("rd_data", m0_rdata, 32'hDEADBEEF);
        // Cycle-by-cycle vector table.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            m0_req = tbl[i].r0; m0_lock = tbl[i].l0; m1_req = tbl[i].r1; m1_lock = tbl[i].l1;
            m0_read = 1; m1_read = 1;
            @(negedge clk);
            chk($sformatf("tbl%0d", i), {gnt, m0_ack, m1_ack}, {tbl[i].g, tbl[i].a0, tbl[i].a1});
            tick();
        end
        // Locked master 0 against a waiting master 1: forced release after ML transfers.
        do_reset();
        m0_req = 1; m0_lock = 1; m0_read = 1; m1_req = 1; m1_read = 1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m1_ack) break;
            if (m0_ack) cnt++;
            tick();
        end
        chk("lock_run", cnt, ML);
        chk("lock_release", {gnt, m1_ack, m0_ack}, 4'b1010);
        // Tie after a master 0 transfer.
        do_reset();
        m0_req = 1; m0_read = 1;
        tick();
        tick();
        m1_req = 1; m1_read = 1;
        @(negedge clk);
        chk("tie_wait", gnt, 2'b00);
        tick();
        @(negedge clk);
        chk("tie_winner", gnt, RR ? 2'b10 : 2'b01);
        // Reset in the middle of a master 1 write.
        do_reset();
        m1_req = 1; m1_write = 1; m1_addr = 32'h20; m1_wdata = 32'h5;
        tick();
        @(negedge clk);
        chk("midrst_before", {gnt, bus_write, m1_ack}, 4'b1011);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_after", {gnt, bus_write, m1_ack}, 4'b0000);
        reset = 1'b1;
        // Randomized traffic against the model.
        do_reset();
        owner = -1; run = 0; last = 1;
        for (int c = 0; c < 400; c++) begin
            reset = $urandom_range(0, 39) != 0;
            m0_req = $urandom_range(0, 3) != 0; m1_req = $urandom_range(0, 3) != 0;
            m0_lock = $urandom_range(0, 2) == 0; m1_lock = $urandom_range(0, 2) == 0;
            m0_read = 1'($urandom_range(0, 1)); m0_write = 1'($urandom_range(0, 1));
            m1_read = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 1));
            m0_addr = 32'($urandom_range(0, 63)); m1_addr = 32'($urandom_range(0, 63));
            m0_wdata = $urandom; m1_wdata = $urandom;
            @(negedge clk);
            model_check();
            model_step();
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
